ifu_prefetch: RTL



---
 rtl/ifu_pkg.sv | 15 +
 rtl/ifu_inst_fifo.sv | 61 ++++++
 rtl/ifu_prefetch.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: default widths, the
// reset fetch address, the canonical NOP encoding and the prefetch entry type.
package ifu_pkg;

  localparam int unsigned IFU_XLEN     = 32;
  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP          = 32'h0000_0013;

  // One prefetched instruction together with the address it was fetched from.
  typedef struct packed {
    logic [IFU_XLEN-1:0] pc;
    logic [31:0]         inst;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_inst_fifo.sv
// Prefetch buffer: a synchronous FIFO of fetch entries with a single-cycle
// flush, an occupancy count, and same-cycle push/pop honoured even when full.
// The head entry reads as all zeros while the buffer is empty.
module ifu_inst_fifo
  import ifu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  output fetch_entry_t head_o,
  output logic         empty_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rdPtr_q;
  logic [AW-1:0] wrPtr_q;
  logic [CW-1:0] count_q;
  logic          full;
  logic          doPush;
  logic          doPop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign doPop   = pop_i && !empty_o;
  assign doPush  = push_i && (!full || doPop);
  assign head_o  = empty_o ? '0 : mem_q[rdPtr_q];
  assign count_o = count_q;

  // Pointer and occupancy bookkeeping; a flush empties the buffer outright.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; needs no reset because the count gates what is visible.
  always_ff @(posedge clk) begin
    if (doPush && !flush_i && !rst) begin
      mem_q[wrPtr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction fetch unit with prefetch buffer. Generates sequential word
// addresses, keeps up to MAX_OUTST requests in flight, and hands {pc, inst}
// pairs to the decoder. Issue is credit-limited so every response that is
// not being dropped is guaranteed a buffer slot. A jump redirect flushes the
// buffer and marks all still-in-flight responses to be discarded on arrival.
// Optional performance counters are enabled by defining IFU_PERF_CNT_EN.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int unsigned      XLEN       = IFU_XLEN,
  parameter logic [XLEN-1:0]  RESET_PC   = IFU_RESET_PC,
  parameter int unsigned      FIFO_DEPTH = 4,
  parameter int unsigned      MAX_OUTST  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_flush_cnt,
  output logic [31:0]     perf_stall_cnt
`endif
);

  localparam int unsigned OW = $clog2(MAX_OUTST + 1);
  localparam int unsigned QW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0] fetchPc_q, fetchPc_d;
  logic [XLEN-1:0] pcQueue_q [MAX_OUTST];
  logic [QW-1:0]   pcWr_q, pcRd_q;
  logic [OW-1:0]   outst_q, outst_d;
  logic [OW-1:0]   drop_q, drop_d;

  logic [CW-1:0]   fifoCount;
  logic            fifoEmpty;
  fetch_entry_t    fifoHead;
  fetch_entry_t    fifoWrData;

  logic            outstOk;
  logic            creditOk;
  logic            reqFire;
  logic            rspFire;
  logic            rspKeep;
  logic            instFire;

  // Advance a PC-queue pointer, wrapping at the queue depth.
  function automatic logic [QW-1:0] qNext(input logic [QW-1:0] p);
    if (int'(p) == int'(MAX_OUTST) - 1) return '0;
    return p + 1'b1;
  endfunction

  assign outstOk        = int'(outst_q) < int'(MAX_OUTST);
  assign creditOk       = (int'(fifoCount) + int'(outst_q)) < int'(FIFO_DEPTH);
  assign imem_req_valid = !rst && !redirect_valid && outstOk && creditOk;
  assign imem_req_addr  = fetchPc_q;
  assign reqFire        = imem_req_valid && imem_req_ready;

  // Beats arriving with nothing outstanding are leftovers from before a reset.
  assign rspFire = imem_rsp_valid && (outst_q != '0);
  assign rspKeep = rspFire && (drop_q == '0) && !redirect_valid;

  assign inst_valid = !fifoEmpty && !redirect_valid;
  assign instFire   = inst_valid && inst_ready;
  assign inst_pc    = fifoHead.pc;
  assign inst_data  = fifoHead.inst;

  assign fifoWrData = '{pc: pcQueue_q[pcRd_q], inst: imem_rsp_data};

  // Next fetch address, in-flight count and drop count; a redirect overrides
  // the fetch address and condemns every request still in flight.
  always_comb begin
    fetchPc_d = fetchPc_q;
    outst_d   = outst_q;
    drop_d    = drop_q;
    if (reqFire) fetchPc_d = fetchPc_q + XLEN'(4);
    if (redirect_valid) fetchPc_d = redirect_pc & ~XLEN'(3);
    case ({reqFire, rspFire})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase
    if (redirect_valid) begin
      drop_d = outst_d;
    end else if (rspFire && (drop_q != '0)) begin
      drop_d = drop_q - 1'b1;
    end
  end

  // Fetch-side state registers and PC-queue pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetchPc_q <= RESET_PC;
      outst_q   <= '0;
      drop_q    <= '0;
      pcWr_q    <= '0;
      pcRd_q    <= '0;
    end else begin
      fetchPc_q <= fetchPc_d;
      outst_q   <= outst_d;
      drop_q    <= drop_d;
      if (reqFire) pcWr_q <= qNext(pcWr_q);
      if (rspFire) pcRd_q <= qNext(pcRd_q);
    end
  end

  // Remember the address of each accepted request so its response can be tagged.
  always_ff @(posedge clk) begin
    if (reqFire) begin
      pcQueue_q[pcWr_q] <= fetchPc_q;
    end
  end

  ifu_inst_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (redirect_valid),
    .push_i     (rspKeep),
    .push_data_i(fifoWrData),
    .pop_i      (instFire),
    .head_o     (fifoHead),
    .empty_o    (fifoEmpty),
    .count_o    (fifoCount)
  );

`ifdef IFU_PERF_CNT_EN
  // Delivered-instruction, redirect and decoder-starvation event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (instFire)                 perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (redirect_valid)           perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (inst_ready && !inst_valid) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
